// File: rtl/clk_rst_seq_pkg.sv
// Shared types and constants for the clock/reset bring-up sequencer.
package clk_rst_seq_pkg;

  typedef enum logic [2:0] {
    PRST,
    WAIT_LOCK,
    STABLE,
    CLK_ON,
    RUN
  } state_t;

  localparam int RELOCK_W = 8;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer; both flops clear asynchronously on rst_n.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// PLL reset / lock qualification / DDR clock enable / core reset release sequencer.
// Runs on the board reference clock so it keeps working while the PLL is unlocked.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int INIT_DELAY     = 5000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked,
  output logic                pll_areset,
  output logic                ddr_clk_en,
  output logic                core_rst_n,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int CNT_MAX = max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, INIT_DELAY);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_DELAY - 1);

  logic rst_sync_n;
  logic lk_s;

  sync2 u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [RELOCK_W-1:0]  relock_next;
  logic                 pll_areset_next, ddr_clk_en_next, core_rst_n_next, ready_next;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 1'b1;
    relock_next = relock_cnt;
    case (state)
      PRST: begin
        if (cnt == PRST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == WAIT_LAST) begin
          state_next = PRST;
          cnt_next   = '0;
        end
      end
      STABLE: begin
        // a single unlocked sample restarts the qualification window
        if (!lk_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = CLK_ON;
          cnt_next   = '0;
        end
      end
      CLK_ON: begin
        if (!lk_s) begin
          state_next = PRST;
          cnt_next   = '0;
        end else if (cnt == INIT_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lk_s) begin
          state_next = PRST;
          if (relock_cnt != '1) relock_next = relock_cnt + 1'b1;
        end
      end
      default: begin
        state_next = PRST;
        cnt_next   = '0;
      end
    endcase

    // outputs are registered from the next state so they move on the same edge as the state
    pll_areset_next = (state_next == PRST);
    ddr_clk_en_next = (state_next == CLK_ON) || (state_next == RUN);
    core_rst_n_next = (state_next == RUN);
    ready_next      = (state_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRST;
      cnt        <= '0;
      pll_areset <= 1'b1;
      ddr_clk_en <= 1'b0;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
      relock_cnt <= '0;
    end else if (!rst_sync_n) begin
      state      <= PRST;
      cnt        <= '0;
      pll_areset <= 1'b1;
      ddr_clk_en <= 1'b0;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
      relock_cnt <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      pll_areset <= pll_areset_next;
      ddr_clk_en <= ddr_clk_en_next;
      core_rst_n <= core_rst_n_next;
      ready      <= ready_next;
      relock_cnt <= relock_next;
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Randomized and directed checks of clk_rst_seq against a phase/duration reference model.
module tb_clk_rst_seq;

  localparam int T_PRST   = 4;
  localparam int T_WAIT   = 32;
  localparam int T_STABLE = 8;
  localparam int T_INIT   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_areset, ddr_clk_en, core_rst_n, ready;
  logic [7:0] relock_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  clk_rst_seq #(
    .PLL_RST_CYCLES (T_PRST),
    .LOCK_TIMEOUT   (T_WAIT),
    .STABLE_CYCLES  (T_STABLE),
    .INIT_DELAY     (T_INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_areset (pll_areset),
    .ddr_clk_en (ddr_clk_en),
    .core_rst_n (core_rst_n),
    .ready      (ready),
    .relock_cnt (relock_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bring-up is a sequence of timed phases.
  // phase 0 = PLL held in reset, 1 = waiting for lock, 2 = qualifying lock,
  // 3 = DDR clock on / core in reset, 4 = running.
  int m_release = 0;
  int m_lk1 = 0, m_lk2 = 0;
  int m_phase = 0, m_age = 0, m_relock = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_release <= 0; m_lk1 <= 0; m_lk2 <= 0;
      m_phase <= 0; m_age <= 0; m_relock <= 0;
    end else begin
      m_lk1 <= int'(pll_locked);
      m_lk2 <= m_lk1;
      if (m_release < 2) begin
        m_release <= m_release + 1;
        m_phase <= 0; m_age <= 0;
      end else begin
        m_age <= m_age + 1;
        if (m_phase == 0 && m_age + 1 == T_PRST) begin
          m_phase <= 1; m_age <= 0;
        end else if (m_phase == 1 && m_lk2 == 1) begin
          m_phase <= 2; m_age <= 0;
        end else if (m_phase == 1 && m_age + 1 == T_WAIT) begin
          m_phase <= 0; m_age <= 0;
        end else if (m_phase == 2 && m_lk2 == 0) begin
          m_phase <= 1; m_age <= 0;
        end else if (m_phase == 2 && m_age + 1 == T_STABLE) begin
          m_phase <= 3; m_age <= 0;
        end else if (m_phase >= 3 && m_lk2 == 0) begin
          if (m_phase == 4 && m_relock < 255) m_relock <= m_relock + 1;
          m_phase <= 0; m_age <= 0;
        end else if (m_phase == 3 && m_age + 1 == T_INIT) begin
          m_phase <= 4; m_age <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pll_areset", int'(pll_areset), int'(m_phase == 0));
      check("ddr_clk_en", int'(ddr_clk_en), int'(m_phase >= 3));
      check("core_rst_n", int'(core_rst_n), int'(m_phase == 4));
      check("ready", int'(ready), int'(m_phase == 4));
      check("relock_cnt", int'(relock_cnt), m_relock);
      check("ddr_and_areset", int'(ddr_clk_en && pll_areset), 0);
      check("ready_implies_core", int'(ready && !core_rst_n), 0);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (ready) break;
    end
    check(name, int'(ready), 1);
  endtask

  initial begin
    int fa, dr, rr, cr, r1, r2, f1, ddr_hi, prev;
    #3 rst_n = 1'b0;
    chk_en = 1'b1;

    // Scenario 1: lock arrives at cycle 20 and stays.
    pll_locked = 1'b0;
    do_reset();
    fa = -1; dr = -1; rr = -1; cr = -1;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      if (fa < 0 && !pll_areset) fa = e;
      if (dr < 0 && ddr_clk_en) dr = e;
      if (rr < 0 && ready) rr = e;
      if (cr < 0 && core_rst_n) cr = e;
      if (e == 19) pll_locked = 1'b1;
    end
    check("s1_areset_fall", fa, 6);
    check("s1_ddr_rise", dr, 30);
    check("s1_ready_rise", rr, 40);
    check("s1_core_rise", cr, 40);
    $display("scenario 1 normal bring-up: areset_fall=%0d ddr_rise=%0d ready_rise=%0d", fa, dr, rr);

    // Scenario 4: 300 lock losses from RUN.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (i < 5) check("s4_ready_before", int'(ready), 1);
      @(posedge clk); #1;
      check("s4_ready_drop", int'(ready), 0);
      check("s4_core_drop", int'(core_rst_n), 0);
      check("s4_ddr_drop", int'(ddr_clk_en), 0);
      check("s4_areset_up", int'(pll_areset), 1);
      if (i == 0) check("s4_relock_first", int'(relock_cnt), 1);
      pll_locked = 1'b1;
      wait_ready(100, "s4_wait_ready");
    end
    check("s4_relock_sat", int'(relock_cnt), 255);
    $display("scenario 4 relock: relock_cnt=%0d", relock_cnt);

    // Scenario 5: reset pulse while in CLK_ON.
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1 pll_locked = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (ddr_clk_en) break;
    end
    check("s5_reach_clk_on", int'(ddr_clk_en && !ready), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_areset", int'(pll_areset), 1);
    check("s5_rst_ddr", int'(ddr_clk_en), 0);
    check("s5_rst_core", int'(core_rst_n), 0);
    check("s5_rst_ready", int'(ready), 0);
    check("s5_rst_relock", int'(relock_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(60, "s5_wait_ready");
    $display("scenario 5 reset in CLK_ON: ready=%0d relock_cnt=%0d", ready, relock_cnt);

    // Scenario 2: lock never arrives.
    pll_locked = 1'b0;
    do_reset();
    r1 = -1; r2 = -1; f1 = -1; ddr_hi = 0; prev = 1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk); #1;
      if (!prev && pll_areset) begin
        if (r1 < 0) r1 = e;
        else if (r2 < 0) r2 = e;
      end
      if (prev && !pll_areset && r1 >= 0 && f1 < 0) f1 = e;
      prev = int'(pll_areset);
      ddr_hi += int'(ddr_clk_en);
    end
    check("s2_first_repulse", r1, 38);
    check("s2_period", r2 - r1, 36);
    check("s2_width", f1 - r1, 4);
    check("s2_ddr_never", ddr_hi, 0);
    $display("scenario 2 no lock: repulse=%0d period=%0d width=%0d", r1, r2 - r1, f1 - r1);

    // Scenario 3: one-cycle lock glitch after 5 qualifying cycles.
    pll_locked = 1'b1;
    do_reset();
    dr = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (dr < 0 && ddr_clk_en) dr = e;
      if (e == 10) pll_locked = 1'b0;
      if (e == 11) pll_locked = 1'b1;
    end
    check("s3_ddr_rise", dr, 22);
    $display("scenario 3 glitch: ddr_rise=%0d", dr);

    // Random lock behaviour with occasional reset pulses; the model checks every cycle.
    for (int b = 0; b < 80; b++) begin
      int len;
      len = $urandom_range(1, 60);
      repeat (len) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end else begin
        pll_locked = ~pll_locked;
      end
    end
    $display("random phase: relock_cnt=%0d", relock_cnt);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, meaning the number of cycles pll_areset is held high per PLL reset.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536, meaning the maximum cycles to wait for a synchronized lock before re-resetting the PLL.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, meaning the number of consecutive locked cycles required before the output clock is enabled.
REQ-004 SHALL have parameter INIT_DELAY, default 5000, meaning the cycles from DDR clock enable to core reset release (100 us at 50 MHz).
REQ-005 SHALL have port clk, input, 1 bit: board reference clock, the same clock feeding PLL inclk0; never a PLL output.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL locked flag, asynchronous to clk.
REQ-008 SHALL have port pll_areset, output, 1 bit: PLL reset request, active high.
REQ-009 SHALL have port ddr_clk_en, output, 1 bit: drives the DDR clock output cell's outclocken and oe.
REQ-010 SHALL have port core_rst_n, output, 1 bit: active-low reset to the core logic.
REQ-011 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port relock_cnt, output, 8 bits: saturating count of lock losses after RUN was first reached.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer (lk_s); all decisions SHALL use lk_s only.
REQ-014 SHALL implement states PRST, WAIT_LOCK, STABLE, CLK_ON and RUN with one shared down/up counter cnt, width clog2 of the largest parameter plus 1.
REQ-015 In PRST: pll_areset=1; after PLL_RST_CYCLES cycles the state SHALL go to WAIT_LOCK with cnt cleared.
REQ-016 In WAIT_LOCK: lk_s=1 SHALL go to STABLE with cnt cleared; cnt reaching LOCK_TIMEOUT-1 with lk_s=0 SHALL go to PRST.
REQ-017 In STABLE: lk_s=0 on any cycle SHALL return to WAIT_LOCK with cnt cleared (glitch filter); STABLE_CYCLES consecutive lk_s=1 cycles SHALL go to CLK_ON.
REQ-018 In CLK_ON: ddr_clk_en=1 and core_rst_n=0; after INIT_DELAY cycles the state SHALL go to RUN.
REQ-019 In RUN: ddr_clk_en=1, core_rst_n=1, ready=1.
REQ-020 lk_s=0 in CLK_ON or RUN SHALL go to PRST on the next edge; ddr_clk_en, core_rst_n and ready SHALL drop in that same cycle, with no extra registered latency.
REQ-021 relock_cnt SHALL increment on each RUN-to-PRST transition, SHALL saturate at 255, and SHALL not increment on a CLK_ON-to-PRST transition.
REQ-022 All outputs SHALL be registered, except that core_rst_n SHALL also be asynchronously forced low by rst_n.
REQ-023 core_rst_n SHALL rise no earlier than INIT_DELAY cycles after ddr_clk_en rises.
REQ-024 ddr_clk_en SHALL never be high while pll_areset is high.

Reset
REQ-025 rst_n low SHALL asynchronously set: state=PRST, cnt=0, pll_areset=1, ddr_clk_en=0, core_rst_n=0, ready=0, relock_cnt=0, synchronizer flops=0.
REQ-026 rst_n deassertion SHALL be synchronized internally with a 2-flop reset synchronizer.
REQ-027 rst_n asserted mid-sequence, including in RUN, SHALL restart from PRST and SHALL clear relock_cnt.

Structure
REQ-028 A shared package SHALL hold the state enum type (PRST, WAIT_LOCK, STABLE, CLK_ON, RUN) and the relock_cnt width constant.
REQ-029 Sub-module sync2, a generic 2-flop synchronizer, SHALL be instantiated for both pll_locked and the reset release.
REQ-030 The block SHALL sit beside the pll and altddio_out instances in the top level and drive them directly.

Verification
REQ-031 Bench parameters SHALL be PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8 and INIT_DELAY=10.
REQ-032 Scenario: reset release, then pll_locked rises at cycle 20 and stays high -> pll_areset falls at cycle ~6, ddr_clk_en rises 8 cycles after lk_s, core_rst_n and ready rise 10 cycles later.
REQ-033 Scenario: pll_locked held low -> pll_areset re-pulses for 4 cycles every 32+4 cycles; ddr_clk_en stays 0.
REQ-034 Scenario: in STABLE, pll_locked drops for 1 cycle after 5 locked cycles -> returns to WAIT_LOCK; ddr_clk_en rises only after a fresh 8-cycle run.
REQ-035 Scenario: in RUN, pll_locked falls -> within 3 cycles (2 sync + 1) ready=0, core_rst_n=0, ddr_clk_en=0, pll_areset=1, relock_cnt 0->1; 300 such losses -> relock_cnt=255.
REQ-036 Scenario: rst_n pulsed low in CLK_ON -> all outputs reach reset values immediately; relock_cnt=0; full sequence repeats.
REQ-037 Assertions SHALL hold throughout: ddr_clk_en and pll_areset never both 1; ready implies core_rst_n.
